// File: rtl/serializer_stream_pkg.sv
// serializer_stream_pkg: FSM state type and default constants (PARITY state exists only with SERIALIZER_STREAM_PARITY_EN)
package serializer_stream_pkg;
    localparam int MIN_LEN_DEF    = 3;
    localparam int FIFO_DEPTH_DEF = 2;
`ifdef SERIALIZER_STREAM_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
    typedef enum logic {IDLE, SHIFT} state_t;
`endif
endpackage

// File: rtl/serializer_stream_fifo.sv
// serializer_stream_fifo: synchronous FIFO with registered not-full flag, async active-low reset
module serializer_stream_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic         clk_i,
    input  logic         arstn_i,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] din_i,
    output logic [W-1:0] dout_o,
    output logic         empty_o,
    output logic         not_full_o
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   cnt_q, cnt_d;
    logic          not_full_q;
    assign cnt_d      = cnt_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
    assign dout_o     = mem_q[rd_q];
    assign empty_o    = cnt_q == '0;
    assign not_full_o = not_full_q;
    // pointers, occupancy and the not-full flag registered from next occupancy; held not-ready in reset
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            wr_q       <= '0;
            rd_q       <= '0;
            cnt_q      <= '0;
            not_full_q <= 1'b0;
        end else begin
            wr_q       <= wr_q + AW'(push_i);
            rd_q       <= rd_q + AW'(pop_i);
            cnt_q      <= cnt_d;
            not_full_q <= cnt_d != (AW+1)'(DEPTH);
        end
    end
    // storage needs no reset; occupancy decides what is valid
    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_q] <= din_i;
    end
endmodule

// File: rtl/serializer_stream.sv
// serializer_stream: buffered parallel-to-serial converter; SERIALIZER_STREAM_PARITY_EN appends an even-parity bit per word
module serializer_stream
    import serializer_stream_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int MOD_W      = $clog2(DATA_W),
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int MIN_LEN    = MIN_LEN_DEF
) (
    input  logic              clk_i,
    input  logic              arstn_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [MOD_W-1:0]  data_mod_i,
    input  logic              lsb_first_i,
    input  logic              data_val_i,
    output logic              data_rdy_o,
    output logic              ser_data_o,
    output logic              ser_data_val_o,
    output logic              ser_last_o,
    output logic              busy_o,
    output logic              drop_o
);
    localparam int LW = MOD_W + 1;
    localparam int EW = DATA_W + LW + 1;
    state_t            state_q, state_d;
    logic [LW-1:0]     cnt_q, cnt_d, len_w, head_len_w;
    logic [DATA_W-1:0] sh_q, sh_d, head_data_w;
    logic              lsb_q, lsb_d, par_q, par_d, drop_q;
    logic              short_w, acc_w, push_w, pop_w, empty_w, rdy_w, head_lsb_w, bit_w, last_bit_w;
    logic [EW-1:0]     head_w;
    assign len_w      = (data_mod_i == '0) ? LW'(DATA_W) : {1'b0, data_mod_i};
    assign short_w    = len_w < LW'(MIN_LEN);
    assign acc_w      = data_val_i & rdy_w;
    assign push_w     = acc_w & ~short_w;
    assign {head_data_w, head_len_w, head_lsb_w} = head_w;
    assign bit_w      = lsb_q ? sh_q[0] : sh_q[DATA_W-1];
    assign last_bit_w = (state_q == SHIFT) && (cnt_q == LW'(1));
    assign data_rdy_o     = rdy_w;
    assign drop_o         = drop_q;
    assign ser_data_val_o = state_q != IDLE;
    assign busy_o         = ~empty_w | (state_q != IDLE);
`ifdef SERIALIZER_STREAM_PARITY_EN
    assign ser_data_o = (state_q == PARITY) ? par_q : ((state_q == SHIFT) & bit_w);
    assign ser_last_o = state_q == PARITY;
`else
    assign ser_data_o = (state_q == SHIFT) & bit_w;
    assign ser_last_o = last_bit_w;
`endif
    serializer_stream_fifo #(.W(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i      (clk_i),
        .arstn_i    (arstn_i),
        .push_i     (push_w),
        .pop_i      (pop_w),
        .din_i      ({data_i, len_w, lsb_first_i}),
        .dout_o     (head_w),
        .empty_o    (empty_w),
        .not_full_o (rdy_w)
    );
    // state and shift datapath registers; reset drops any partial word
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
            lsb_q   <= 1'b0;
            par_q   <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            lsb_q   <= lsb_d;
            par_q   <= par_d;
            drop_q  <= acc_w & short_w;
        end
    end
    // next state: shift one bit per cycle, load the next buffered word straight after the last bit
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        lsb_d   = lsb_q;
        par_d   = par_q;
        if (state_q == SHIFT) begin
            sh_d  = lsb_q ? (sh_q >> 1) : (sh_q << 1);
            cnt_d = cnt_q - LW'(1);
            par_d = par_q ^ bit_w;
        end
`ifdef SERIALIZER_STREAM_PARITY_EN
        if (last_bit_w) state_d = PARITY;
        pop_w = ((state_q == IDLE) || (state_q == PARITY)) && !empty_w;
        if ((state_q == PARITY) && empty_w) state_d = IDLE;
`else
        pop_w = ((state_q == IDLE) || last_bit_w) && !empty_w;
        if (last_bit_w && empty_w) state_d = IDLE;
`endif
        if (pop_w) begin
            state_d = SHIFT;
            sh_d    = head_data_w;
            cnt_d   = head_len_w;
            lsb_d   = head_lsb_w;
            par_d   = 1'b0;
        end
    end
endmodule

// File: tb/tb_serializer_stream.sv
// tb_serializer_stream: directed table-driven bench for serializer_stream (honours SERIALIZER_STREAM_PARITY_EN)
module tb_serializer_stream;
    logic        clk_i = 1'b0, arstn_i = 1'b0;
    logic [15:0] data_i = '0;
    logic [3:0]  data_mod_i = '0;
    logic        lsb_first_i = 1'b0, data_val_i = 1'b0;
    logic        data_rdy_o, ser_data_o, ser_data_val_o, ser_last_o, busy_o, drop_o;

    serializer_stream dut (
        .clk_i(clk_i), .arstn_i(arstn_i), .data_i(data_i), .data_mod_i(data_mod_i),
        .lsb_first_i(lsb_first_i), .data_val_i(data_val_i), .data_rdy_o(data_rdy_o),
        .ser_data_o(ser_data_o), .ser_data_val_o(ser_data_val_o), .ser_last_o(ser_last_o),
        .busy_o(busy_o), .drop_o(drop_o)
    );

    always #5 clk_i = ~clk_i;

    int errors = 0, checks = 0, cyc = 0, drop_cnt = 0;
    bit bad_idle = 0, rdy_low = 0;
    bit bq[$];
    bit lq[$];
    int tq[$];

    typedef struct {
        logic [15:0] data;
        logic [3:0]  mod;
        logic        lsb;
        logic [15:0] exp;
        int          n;
        int          drops;
    } vec_t;
    vec_t vt[9];

    always @(posedge clk_i) cyc <= cyc + 1;

    always @(negedge clk_i) begin
        if (ser_data_val_o) begin
            bq.push_back(ser_data_o);
            lq.push_back(ser_last_o);
            tq.push_back(cyc);
        end else if (ser_data_o || ser_last_o) bad_idle = 1;
        if (drop_o) drop_cnt++;
        if (arstn_i && !data_rdy_o) rdy_low = 1;
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    task automatic clear_mon();
        bq.delete();
        lq.delete();
        tq.delete();
        drop_cnt = 0;
        bad_idle = 0;
        rdy_low  = 0;
    endtask

    task automatic send(input logic [15:0] d, input logic [3:0] m, input logic l);
        int t = 0;
        @(negedge clk_i);
        while (!data_rdy_o && t < 200) begin
            @(negedge clk_i);
            t++;
        end
        if (t >= 200) fail_now("send_rdy");
        data_i = d;
        data_mod_i = m;
        lsb_first_i = l;
        data_val_i = 1'b1;
        @(posedge clk_i);
        #1 data_val_i = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int t = 0;
        @(negedge clk_i);
        while (busy_o && t < 500) begin
            @(negedge clk_i);
            t++;
        end
        if (t >= 500) fail_now(name);
    endtask

    task automatic check_stream(input string name, input logic [127:0] exp, input logic [127:0] exp_last, input int n);
        logic [127:0] a = '0, l = '0;
        bit gap = 0;
        chk({name, "_nbits"}, 128'(bq.size()), 128'(n));
        foreach (bq[i]) begin
            a = (a << 1) | 128'(bq[i]);
            l = (l << 1) | 128'(lq[i]);
            if (tq[i] != tq[0] + i) gap = 1;
        end
        chk({name, "_bits"}, a, exp);
        chk({name, "_last"}, l, exp_last);
        chk({name, "_gap_idle"}, {126'd0, gap, bad_idle}, 128'd0);
    endtask

    // appends the per-word parity bit when the option is built in
    function automatic logic [127:0] with_par(input logic [127:0] bits, input int n);
`ifdef SERIALIZER_STREAM_PARITY_EN
        return (n == 0) ? bits : ((bits << 1) | 128'(^bits));
`else
        return bits + 128'(n - n);
`endif
    endfunction

    localparam int PB =
`ifdef SERIALIZER_STREAM_PARITY_EN
        1;
`else
        0;
`endif

    initial begin
        logic [127:0] e, el;
        logic [15:0]  w[4];
        int n, t;
        vt[0] = '{16'hA5C3, 4'd0, 1'b0, 16'b1010010111000011, 16, 0};
        vt[1] = '{16'h000B, 4'd4, 1'b1, 16'hD000, 4, 0};
        vt[2] = '{16'hF000, 4'd4, 1'b0, 16'hF000, 4, 0};
        vt[3] = '{16'h0007, 4'd3, 1'b1, 16'hE000, 3, 0};
        vt[4] = '{16'h8001, 4'd0, 1'b1, 16'h8001, 16, 0};
        vt[5] = '{16'hC5A0, 4'd5, 1'b0, 16'hC000, 5, 0};
        vt[6] = '{16'h0036, 4'd6, 1'b1, 16'h6C00, 6, 0};
        vt[7] = '{16'hFFFF, 4'd2, 1'b0, 16'h0000, 0, 1};
        vt[8] = '{16'hFFFF, 4'd1, 1'b1, 16'h0000, 0, 1};

        repeat (3) @(negedge clk_i);
        chk("reset_outputs", {122'd0, data_rdy_o, ser_data_o, ser_data_val_o, ser_last_o, busy_o, drop_o}, 128'd0);
        arstn_i = 1'b1;
        @(negedge clk_i);
        chk("rdy_after_release", 128'(data_rdy_o), 128'd1);

        for (int i = 0; i < 9; i++) begin
            clear_mon();
            send(vt[i].data, vt[i].mod, vt[i].lsb);
            @(negedge clk_i);
            chk($sformatf("v%0d_lat0", i), 128'(ser_data_val_o), 128'd0);
            @(negedge clk_i);
            chk($sformatf("v%0d_lat1", i), 128'(ser_data_val_o), 128'(vt[i].n != 0));
            wait_idle($sformatf("v%0d_idle", i));
            e = (vt[i].n == 0) ? 128'd0 : (128'(vt[i].exp) >> (16 - vt[i].n));
            n = (vt[i].n == 0) ? 0 : vt[i].n + PB;
            check_stream($sformatf("v%0d", i), with_par(e, vt[i].n), 128'(n != 0), n);
            chk($sformatf("v%0d_drops", i), 128'(drop_cnt), 128'(vt[i].drops));
        end

        clear_mon();
        send(16'h000B, 4'd4, 1'b1);
        send(16'hF000, 4'd4, 1'b0);
        wait_idle("b2b_idle");
        e  = (with_par(128'hD, 4) << (4 + PB)) | with_par(128'hF, 4);
        el = (128'd1 << (4 + PB)) | 128'd1;
        check_stream("b2b", e, el, 8 + 2 * PB);

        clear_mon();
        w = '{16'hA5C3, 16'h1234, 16'hFFFF, 16'h0F0F};
        e = '0;
        el = '0;
        for (int i = 0; i < 4; i++) begin
            send(w[i], 4'd0, 1'b0);
            e  = (e << (16 + PB)) | with_par(128'(w[i]), 16);
            el = (el << (16 + PB)) | 128'd1;
        end
        wait_idle("full_idle");
        chk("full_rdy_low", 128'(rdy_low), 128'd1);
        check_stream("full", e, el, 64 + 4 * PB);

        clear_mon();
        send(16'hA5C3, 4'd0, 1'b0);
        t = 0;
        while (bq.size() < 5 && t < 100) begin
            @(negedge clk_i);
            #1 t++;
        end
        if (t >= 100) fail_now("rst_mid_wait");
        #1 arstn_i = 1'b0;
        #1 chk("rst_mid_outputs", {122'd0, data_rdy_o, ser_data_o, ser_data_val_o, ser_last_o, busy_o, drop_o}, 128'd0);
        @(negedge clk_i);
        arstn_i = 1'b1;
        clear_mon();
        send(16'h3C96, 4'd0, 1'b1);
        wait_idle("rst_new_idle");
        check_stream("rst_new", with_par(128'h693C, 16), 128'd1, 16 + PB);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
